// File: rtl/pipe_add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Holds the operation encoding, the result flag bundle and the
// elaboration-time configuration check.
package pipe_add_pkg;

  // Operation select: ADD computes a+b, SUB computes a+~b+1.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Status flags that travel with every result.
  typedef struct packed {
    logic carry_out;
    logic overflow;
    logic zero;
  } result_flags_t;

  // Legal configuration: 1 <= stages <= width and width divides evenly.
  function automatic bit width_ok(input int unsigned width,
                                  input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_sub_add_chunk.sv
// One CHUNK-bit slice of the carry chain: plain combinational adder
// with carry in and carry out. One instance per pipeline stage.
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  // Widen by one bit so the carry out falls into the top position.
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chained
// chunks, one chunk per stage. Result carries carry, signed-overflow and
// zero flags.
//
// Optional feature: define PIPE_ADD_SUB_SAT_EN to clamp the sum on signed
// overflow instead of wrapping modulo 2^WIDTH.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is combinational from out_ready through the stage
// chain; a stalled stage holds its contents and out_valid never drops
// without an output transfer.
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Full result bundle presented on the output.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    result_flags_t    flags;
  } result_t;

  if (!width_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Stage registers. Each stage keeps the whole operand pair (higher
  // chunks are the skew registers, lower ones are already consumed) and
  // the partial sum whose chunks 0..k are final after stage k.
  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;

  // Values feeding each stage's adder (from the ports for stage 0,
  // from the previous stage register otherwise).
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [STAGES-1:0] cin_in;
  logic [STAGES-1:0] up_v;

  // Per-stage chunk adder wiring.
  logic [STAGES-1:0][CHUNK-1:0] ch_a, ch_b, ch_s;
  logic [STAGES-1:0]            ch_co;

  // Stage k may load new contents this cycle.
  logic [STAGES-1:0] rdy;

  addsub_op_e op_e;
  assign op_e = addsub_op_e'(op);

  // Stage inputs: SUB inversion and cin = 1 are applied only at stage 0.
  always_comb begin
    a_in[0]   = operand1;
    b_in[0]   = (op_e == OP_SUB) ? ~operand2 : operand2;
    s_in[0]   = '0;
    cin_in[0] = (op_e == OP_SUB);
    up_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      s_in[k]   = s_q[k-1];
      cin_in[k] = c_q[k-1];
      up_v[k]   = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      ch_a[k] = a_in[k][k*CHUNK +: CHUNK];
      ch_b[k] = b_in[k][k*CHUNK +: CHUNK];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    add_chunk #(.W(CHUNK)) u_add_chunk (
      .a_i    (ch_a[g]),
      .b_i    (ch_b[g]),
      .cin_i  (cin_in[g]),
      .sum_o  (ch_s[g]),
      .cout_o (ch_co[g])
    );
  end

  // Backpressure chain: a stage can load when empty or when its
  // downstream neighbour moves; stalls stop at the first empty stage.
  always_comb begin
    logic r;
    rdy    = '0;
    r      = !v_q[LAST] || out_ready;
    rdy[LAST] = r;
    for (int k = STAGES - 2; k >= 0; k--) begin
      r      = !v_q[k] || r;
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0];

  // Next state: a loading stage takes the upstream valid bit, and data
  // only when that upstream slot actually holds an operation.
  always_comb begin
    v_d = v_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    c_d = c_q;
    for (int k = 0; k < STAGES; k++) begin
      if (rdy[k]) begin
        v_d[k] = up_v[k];
        if (up_v[k]) begin
          a_d[k]                  = a_in[k];
          b_d[k]                  = b_in[k];
          s_d[k]                  = s_in[k];
          s_d[k][k*CHUNK +: CHUNK] = ch_s[k];
          c_d[k]                  = ch_co[k];
        end
      end
    end
  end

  // Stage registers; reset discards everything in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  // Output bundle: flags come from the last stage; the whole bundle
  // reads as zero whenever no result is being presented.
  logic             ovf_raw;
  logic [WIDTH-1:0] sum_pres;
  result_t          res;

  assign ovf_raw = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                   (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

`ifdef PIPE_ADD_SUB_SAT_EN
  // Clamp toward the sign of a when the signed result overflowed.
  always_comb begin
    sum_pres = s_q[LAST];
    if (ovf_raw) begin
      sum_pres = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_pres = s_q[LAST];
`endif

  // Gate the presented result with the final stage valid bit.
  always_comb begin
    res = '0;
    if (v_q[LAST]) begin
      res.sum             = sum_pres;
      res.flags.carry_out = c_q[LAST];
      res.flags.overflow  = ovf_raw;
      res.flags.zero      = (sum_pres == '0);
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = res.sum;
  assign carry_out = res.flags.carry_out;
  assign overflow  = res.flags.overflow;
  assign zero      = res.flags.zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed bench for pipe_add_sub: a 32-bit/4-stage instance and an
// 8-bit/1-stage instance sharing clock and reset.
module tb_pipe_add_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] operand1, operand2, sum;
  logic        carry_out, overflow, zero;

  logic        in_valid8, in_ready8, op8, out_valid8, out_ready8;
  logic [7:0]  operand1_8, operand2_8, sum8;
  logic        carry_out8, overflow8, zero8;

  int n_cmp;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [31:0] got_sum_q[$];
  logic [2:0]  got_flg_q[$];
  int          got_cyc_q[$];

  pipe_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .operand1(operand1_8), .operand2(operand2_8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry_out(carry_out8), .overflow(overflow8), .zero(zero8)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1, "watchdog");
  end

  // Driver: present one op at the current negedge and let it be taken at
  // the next edge. in_valid is left high for back-to-back sends.
  task automatic send(input logic o, input logic [31:0] a, input logic [31:0] b);
    op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: record every output transfer over n cycles (called at negedge).
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_sum_q.push_back(sum);
        got_flg_q.push_back({carry_out, overflow, zero});
        got_cyc_q.push_back(i);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic clear_got();
    got_sum_q.delete();
    got_flg_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0;
    operand1 = '0; operand2 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = 1'b0;
    operand1_8 = '0; operand2_8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", sum); end
    n_cmp++;
    if ({carry_out, overflow, zero} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {carry_out, overflow, zero});
    end
    n_cmp++;
    if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8: got %b want 0", out_valid8); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_add_latency();
    int cnt;
    out_ready = 1'b1;
    op = 1'b0; operand1 = 32'd5; operand2 = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== 4) begin n_fail++; $display("FAIL add_latency: got %0d edges want 4", cnt); end
    n_cmp++;
    if (sum !== 32'd12) begin n_fail++; $display("FAIL add_sum: got %h want %h", sum, 32'd12); end
    n_cmp++;
    if ({carry_out, overflow, zero} !== 3'b000) begin
      n_fail++; $display("FAIL add_flags: got %b want 000", {carry_out, overflow, zero});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    clear_got();
    out_ready = 1'b1;
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    send(1'b1, 32'h0000_0005, 32'h0000_0005);
    in_valid = 1'b0;
    collect(10);
    n_cmp++;
    if (got_sum_q.size() !== 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 2", got_sum_q.size());
    end else begin
      n_cmp++;
      if (got_cyc_q[1] - got_cyc_q[0] !== 1) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d want 1", got_cyc_q[1] - got_cyc_q[0]);
      end
      n_cmp++;
      if (got_sum_q[0] !== 32'h0 || got_flg_q[0] !== 3'b101) begin
        n_fail++; $display("FAIL b2b_wrap: got %h/%b want 00000000/101", got_sum_q[0], got_flg_q[0]);
      end
      n_cmp++;
      if (got_sum_q[1] !== 32'h0 || got_flg_q[1] !== 3'b101) begin
        n_fail++; $display("FAIL b2b_sub_eq: got %h/%b want 00000000/101", got_sum_q[1], got_flg_q[1]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] e0, e1;
`ifdef PIPE_ADD_SUB_SAT_EN
    e0 = 32'h7FFF_FFFF; e1 = 32'h8000_0000;
`else
    e0 = 32'h8000_0000; e1 = 32'h7FFF_FFFF;
`endif
    clear_got();
    out_ready = 1'b1;
    send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    send(1'b1, 32'h8000_0000, 32'h0000_0001);
    in_valid = 1'b0;
    collect(10);
    n_cmp++;
    if (got_sum_q.size() !== 2) begin
      n_fail++; $display("FAIL ovf_count: got %0d want 2", got_sum_q.size());
    end else begin
      n_cmp++;
      if (got_sum_q[0] !== e0 || got_flg_q[0] !== 3'b010) begin
        n_fail++; $display("FAIL ovf_add: got %h/%b want %h/010", got_sum_q[0], got_flg_q[0], e0);
      end
      n_cmp++;
      if (got_sum_q[1] !== e1 || got_flg_q[1] !== 3'b110) begin
        n_fail++; $display("FAIL ovf_sub: got %h/%b want %h/110", got_sum_q[1], got_flg_q[1], e1);
      end
    end
  endtask

  task automatic test_stall_stream();
    logic        op_t [10];
    logic [31:0] a_t  [10];
    logic [31:0] b_t  [10];
    logic [31:0] e_t  [10];
    logic [31:0] prev_sum;
    int          idx, got, cyc;
    op_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    a_t  = '{32'h0000_0010, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFE,
             32'h0000_ABCD, 32'h0F0F_0F0F, 32'h8000_0000, 32'h00FF_00FF, 32'h0000_1000};
    b_t  = '{32'h0000_0020, 32'h0000_0001, 32'h1111_1111, 32'h0000_0001, 32'h0000_0003,
             32'h0000_0BCD, 32'h0101_0101, 32'h8000_0000, 32'h0001_0001, 32'h0000_2000};
    e_t  = '{32'h0000_0030, 32'h0000_00FF, 32'h2345_6789, 32'hFFFF_FFFF, 32'h0000_0001,
             32'h0000_A000, 32'h1010_1010, 32'h0000_0000, 32'h0100_0100, 32'hFFFF_F000};
    exp_q.delete();
    idx = 0; got = 0; cyc = 0; prev_sum = '0;
    while (got < 10 && cyc < 100) begin
      out_ready = !(cyc >= 6 && cyc < 12);
      if (idx < 10) begin
        in_valid = 1'b1; op = op_t[idx]; operand1 = a_t[idx]; operand2 = b_t[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 7 && cyc < 12) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL stall_valid_hold: cycle %0d got %b want 1", cyc, out_valid);
        end
        n_cmp++;
        if (sum !== prev_sum) begin
          n_fail++; $display("FAIL stall_sum_hold: cycle %0d got %h want %h", cyc, sum, prev_sum);
        end
      end
      if (cyc == 11) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got %h want none", sum);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (sum !== e) begin
            n_fail++; $display("FAIL stream_result: index %0d got %h want %h", got, sum, e);
          end
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(e_t[idx]);
        idx++;
      end
      prev_sum = sum;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got !== 10 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL stream_count: got %0d results, %0d pending want 10, 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(1'b0, 32'd10, 32'd20);
    send(1'b0, 32'd30, 32'd40);
    send(1'b1, 32'd50, 32'd60);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (sum !== 32'h0) begin n_fail++; $display("FAIL mid_reset_sum: got %h want 0", sum); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clear_got();
    send(1'b0, 32'd1, 32'd1);
    in_valid = 1'b0;
    collect(10);
    n_cmp++;
    if (got_sum_q.size() !== 1) begin
      n_fail++; $display("FAIL mid_after_count: got %0d want 1", got_sum_q.size());
    end else begin
      n_cmp++;
      if (got_sum_q[0] !== 32'd2) begin
        n_fail++; $display("FAIL mid_after_sum: got %h want 2", got_sum_q[0]);
      end
    end
  endtask

  task automatic test_width8();
    op8 = 1'b1; operand1_8 = 8'd3; operand2_8 = 8'd4; in_valid8 = 1'b1; out_ready8 = 1'b1;
    #1;
    n_cmp++;
    if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL w8_in_ready: got %b want 1", in_ready8); end
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    n_cmp++;
    if (out_valid8 !== 1'b1) begin n_fail++; $display("FAIL w8_latency: got %b want 1", out_valid8); end
    n_cmp++;
    if (sum8 !== 8'hFF) begin n_fail++; $display("FAIL w8_sum: got %h want ff", sum8); end
    n_cmp++;
    if ({carry_out8, overflow8, zero8} !== 3'b000) begin
      n_fail++; $display("FAIL w8_flags: got %b want 000", {carry_out8, overflow8, zero8});
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_overflow();
    test_stall_stream();
    test_reset_mid();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
